// File: rtl/ps2_calc_core_pkg.sv
// Shared opcodes, FSM encoding and default saturation ceiling for the PS/2 calculator core.
package ps2_calc_core_pkg;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SHOW = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOP6 = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Largest value that still fits four BCD digits.
  localparam int unsigned MAX_VAL_DEFAULT = 9999;

endpackage

// File: rtl/ps2_calc_core_mult.sv
// Radix-2 shift-add multiplier: one partial product per cycle, X_W cycles after start.
// done is high during the final step; product is complete on the following cycle.
module ps2_calc_core_mult #(
  parameter int unsigned DW  = 14,
  parameter int unsigned X_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DW-1:0]       multiplicand,
  input  logic [X_W-1:0]      multiplier,
  output logic                done,
  output logic [DW+X_W-1:0]   product
);

  localparam int unsigned PW = DW + X_W;
  localparam int unsigned CW = $clog2(X_W + 1);
  localparam logic [CW-1:0] LastCnt = CW'(X_W - 1);

  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [X_W-1:0] mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = busy_q && (cnt_q == LastCnt);
    if (start) begin
      acc_d    = '0;
      mcand_d  = PW'(multiplicand);
      mplier_d = multiplier;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/ps2_calc_core.sv
// Command-execution core between the PS/2 driver and the BCD display decoders.
// Define CALC_MUL_EN to build the multi-cycle MUL opcode; otherwise 101 is a NOP and ready stays 1.
module ps2_calc_core
  import ps2_calc_core_pkg::*;
#(
  parameter int unsigned IN_W      = 7,
  parameter int unsigned X_W       = 10,
  parameter int unsigned DW        = 14,
  parameter int unsigned MAX_VAL   = MAX_VAL_DEFAULT,
  parameter int unsigned AUTO_SHOW = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd_op,
  input  logic [IN_W-1:0] entrada,
  output logic            ready,
  output logic [X_W-1:0]  x,
  output logic [DW-1:0]   y,
  output logic [DW-1:0]   z,
  output logic            ovf,
  output logic            dropped
);

  localparam logic [DW:0]   SumMax = (DW + 1)'(MAX_VAL);
  localparam logic [DW-1:0] SatVal = DW'(MAX_VAL);

  logic [X_W-1:0] x_q, x_d;
  logic [DW-1:0]  y_q, y_d, z_q, z_d;
  logic [DW-1:0]  y_new, x_ext;
  logic [DW:0]    sum;
  logic           ovf_q, ovf_d, dropped_q, dropped_d, y_wr;
  state_e         state_q, state_d;

  assign x_ext = DW'(x_q);
  // One extra bit so the saturation test sees the true sum.
  assign sum   = {1'b0, y_q} + {1'b0, x_ext};
  assign ready = (state_q == StIdle);

`ifdef CALC_MUL_EN
  localparam int unsigned PW = DW + X_W;
  localparam logic [PW-1:0] ProdMax = PW'(MAX_VAL);

  logic          mul_start, mul_done;
  logic [PW-1:0] product;

  ps2_calc_core_mult #(
    .DW  (DW),
    .X_W (X_W)
  ) u_mult (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (y_q),
    .multiplier   (x_q),
    .done         (mul_done),
    .product      (product)
  );
`endif

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    ovf_d     = ovf_q;
    dropped_d = dropped_q;
    state_d   = state_q;
    y_new     = y_q;
    y_wr      = 1'b0;
`ifdef CALC_MUL_EN
    mul_start = 1'b0;
`endif

    if (cmd_valid && !ready) dropped_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLR: begin
              x_d       = '0;
              y_d       = '0;
              z_d       = '0;
              ovf_d     = 1'b0;
              dropped_d = 1'b0;
            end
            OP_ADD: begin
              y_wr = 1'b1;
              if (sum > SumMax) begin
                y_new = SatVal;
                ovf_d = 1'b1;
              end else begin
                y_new = sum[DW-1:0];
              end
            end
            OP_SHOW: z_d = y_q;
            OP_LOAD: x_d = X_W'(entrada);
            OP_SUB: begin
              y_wr = 1'b1;
              if (x_ext > y_q) begin
                y_new = '0;
                ovf_d = 1'b1;
              end else begin
                y_new = y_q - x_ext;
              end
            end
`ifdef CALC_MUL_EN
            OP_MUL: begin
              mul_start = 1'b1;
              state_d   = StMul;
            end
`endif
            default: ;
          endcase
        end
      end
`ifdef CALC_MUL_EN
      StMul: begin
        if (mul_done) state_d = StDone;
      end
      StDone: begin
        y_wr    = 1'b1;
        state_d = StIdle;
        if (product > ProdMax) begin
          y_new = SatVal;
          ovf_d = 1'b1;
        end else begin
          y_new = product[DW-1:0];
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (y_wr) begin
      y_d = y_new;
      if (AUTO_SHOW != 0) z_d = y_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      ovf_q     <= 1'b0;
      dropped_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      ovf_q     <= ovf_d;
      dropped_q <= dropped_d;
      state_q   <= state_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign z       = z_q;
  assign ovf     = ovf_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_ps2_calc_core.sv
// Scoreboard bench for ps2_calc_core: a default instance and an AUTO_SHOW=0 instance share stimulus.
module tb_ps2_calc_core;
  import ps2_calc_core_pkg::*;

  localparam int unsigned XW   = 10;
  localparam int unsigned MAXV = 9999;
`ifdef CALC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, cmd_valid;
  logic [2:0]  cmd_op;
  logic [6:0]  entrada;
  logic        ready, ovf, dropped;
  logic [9:0]  x;
  logic [13:0] y, z;
  logic        ready_ns, ovf_ns, dropped_ns;
  logic [9:0]  x_ns;
  logic [13:0] y_ns, z_ns;

  always #5 clk = ~clk;

  ps2_calc_core dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .entrada   (entrada),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .ovf       (ovf),
    .dropped   (dropped)
  );

  ps2_calc_core #(.AUTO_SHOW(0)) dut_ns (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .entrada   (entrada),
    .ready     (ready_ns),
    .x         (x_ns),
    .y         (y_ns),
    .z         (z_ns),
    .ovf       (ovf_ns),
    .dropped   (dropped_ns)
  );

  typedef struct {
    int unsigned x, y, z, zns, ovf, drop;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_x, m_y, m_z, m_zns, m_ovf, m_drop;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = 0; m_zns = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_apply(input logic [2:0] op, input int unsigned ent, input bit inject);
    int unsigned s;
    case (op)
      OP_CLR:  model_reset();
      OP_ADD: begin
        s = m_y + m_x;
        if (s > MAXV) begin m_y = MAXV; m_ovf = 1; end else m_y = s;
        m_z = m_y;
      end
      OP_SHOW: begin m_z = m_y; m_zns = m_y; end
      OP_LOAD: m_x = ent;
      OP_SUB: begin
        if (m_x > m_y) begin m_y = 0; m_ovf = 1; end else m_y = m_y - m_x;
        m_z = m_y;
      end
      OP_MUL: begin
        if (MulEn) begin
          s = m_y * m_x;
          if (s > MAXV) begin m_y = MAXV; m_ovf = 1; end else m_y = s;
          m_z = m_y;
          if (inject) m_drop = 1;
        end
      end
      default: ;
    endcase
    sb.push_back('{m_x, m_y, m_z, m_zns, m_ovf, m_drop});
  endtask

  // Issue one command, wait out any busy period, then retire the oldest expectation.
  task automatic do_cmd(input logic [2:0] op, input logic [6:0] ent, input bit inject);
    exp_t  e;
    int    busy;
    int    exp_busy;
    string t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    entrada   = ent;
    model_apply(op, int'(ent), inject);
    @(negedge clk);
    cmd_valid = 1'b0;
    busy = 0;
    while (!ready && busy < 50) begin
      if (inject && busy == 3) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
      end else begin
        cmd_valid = 1'b0;
      end
      busy++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    exp_busy  = (MulEn && op == OP_MUL) ? XW + 1 : 0;
    t = $sformatf("op%0d", op);
    check_val({t, ".busy"}, busy, exp_busy);
    e = sb.pop_front();
    check_val({t, ".x"}, x, e.x);
    check_val({t, ".y"}, y, e.y);
    check_val({t, ".z"}, z, e.z);
    check_val({t, ".ovf"}, ovf, e.ovf);
    check_val({t, ".dropped"}, dropped, e.drop);
    check_val({t, ".ns_x"}, x_ns, e.x);
    check_val({t, ".ns_y"}, y_ns, e.y);
    check_val({t, ".ns_z"}, z_ns, e.zns);
    check_val({t, ".ns_ovf"}, ovf_ns, e.ovf);
    check_val({t, ".ns_dropped"}, dropped_ns, e.drop);
    check_val({t, ".ns_ready"}, ready_ns, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".ready"}, ready, 1);
    check_val({tag, ".x"}, x, 0);
    check_val({tag, ".y"}, y, 0);
    check_val({tag, ".z"}, z, 0);
    check_val({tag, ".ovf"}, ovf, 0);
    check_val({tag, ".dropped"}, dropped, 0);
    check_val({tag, ".ns_z"}, z_ns, 0);
    check_val({tag, ".ns_ready"}, ready_ns, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_CLR;
    entrada   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    do_cmd(OP_LOAD, 7'd25, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_SHOW, 7'd0, 0);

    do_cmd(OP_LOAD, 7'd127, 0);
    for (int i = 0; i < 79; i++) do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_CLR, 7'd0, 0);

    do_cmd(OP_LOAD, 7'd30, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd40, 0);
    do_cmd(OP_SUB, 7'd0, 0);
    do_cmd(OP_CLR, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd50, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd20, 0);
    do_cmd(OP_SUB, 7'd0, 0);
    do_cmd(OP_NOP6, 7'd99, 0);
    do_cmd(OP_NOP7, 7'd5, 0);
    do_cmd(OP_MUL, 7'd3, 0);

`ifdef CALC_MUL_EN
    do_cmd(OP_CLR, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd12, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd11, 0);
    do_cmd(OP_MUL, 7'd0, 0);
    do_cmd(OP_CLR, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd100, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd127, 0);
    do_cmd(OP_MUL, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd0, 0);
    do_cmd(OP_MUL, 7'd0, 0);
    do_cmd(OP_CLR, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd7, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd6, 0);
    do_cmd(OP_MUL, 7'd0, 1);
`endif

    // Reset during a MUL (a NOP without the multiplier) must return everything to reset values.
    do_cmd(OP_LOAD, 7'd9, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_MUL;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_state("midmul_reset");

    do_cmd(OP_LOAD, 7'd3, 0);
    do_cmd(OP_ADD, 7'd0, 0);
    do_cmd(OP_LOAD, 7'd4, 0);
    do_cmd(OP_MUL, 7'd0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 19) == 0) op = OP_CLR;
      else op = 3'($urandom_range(1, 7));
      do_cmd(op, 7'($urandom_range(0, 127)), (op == OP_MUL) && ($urandom_range(0, 2) == 0));
    end

    check_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
